// File: rtl/cordic_sincos_iter.sv
// Iterative rotation-mode CORDIC: one Q2.22 angle in, cos/sin out, one micro-rotation per clock.
// Latency ITERS+1 edges from accept to out_valid. Output is held while out_ready is low. A new angle is taken only in IDLE.
module cordic_sincos_iter #(
    parameter int WIDTH = 24,
    parameter int FRAC  = 22,
    parameter int ITERS = 22
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_theta,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_cos,
    output logic [WIDTH-1:0] io_out_sin,
    output logic             io_busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int SH = 22 - FRAC;

    // Constants are tabulated for 22 fractional bits and rescaled to FRAC.
    function automatic logic signed [WIDTH-1:0] q(input int v);
        return WIDTH'(v >>> SH);
    endfunction

    localparam logic signed [WIDTH-1:0] HALF_PI = q(6588397);
    localparam logic signed [WIDTH-1:0] X_INIT  = q(2547003);
    localparam logic signed [WIDTH-1:0] ATAN [WIDTH] = '{
        q(3294198), q(1944679), q(1027515), q(521583), q(261803), q(131029),
        q(65531),   q(32767),   q(16384),   q(8192),   q(4096),   q(2048),
        q(1024),    q(512),     q(256),     q(128),    q(64),     q(32),
        q(16),      q(8),       q(4),       q(2),      q(1),      q(0)
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic signed [WIDTH-1:0] r_x, r_y, r_z, r_cos, r_sin;
    logic signed [WIDTH-1:0] w_theta, w_theta_clamp;
    logic signed [WIDTH-1:0] w_x_sh, w_y_sh, w_atan;
    logic signed [WIDTH-1:0] w_x_nxt, w_y_nxt, w_z_nxt;
    logic                    w_accept, w_last, w_neg;

    assign w_theta  = io_in_theta;
    assign w_accept = io_in_valid && io_in_ready;
    // The extra RUN cycle at r_cnt == ITERS moves x/y into the output registers.
    assign w_last   = (r_cnt == CW'(ITERS));

    always_comb begin
        w_theta_clamp = w_theta;
        if (w_theta > HALF_PI)
            w_theta_clamp = HALF_PI;
        else if (w_theta < -HALF_PI)
            w_theta_clamp = -HALF_PI;
    end

    assign w_neg   = r_z[WIDTH-1];
    assign w_x_sh  = r_x >>> r_cnt;
    assign w_y_sh  = r_y >>> r_cnt;
    assign w_atan  = ATAN[r_cnt];
    assign w_x_nxt = w_neg ? r_x + w_y_sh : r_x - w_y_sh;
    assign w_y_nxt = w_neg ? r_y - w_x_sh : r_y + w_x_sh;
    assign w_z_nxt = w_neg ? r_z + w_atan : r_z - w_atan;

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        io_in_ready  = 1'b0;
        io_out_valid = 1'b0;
        io_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                io_in_ready = 1'b1;
                io_busy     = 1'b0;
                if (io_in_valid)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_last)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                io_out_valid = 1'b1;
                if (io_out_ready)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_cos <= '0;
            r_sin <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_x   <= X_INIT;
            r_y   <= '0;
            r_z   <= w_theta_clamp;
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                r_cos <= r_x;
                r_sin <= r_y;
            end else begin
                r_x   <= w_x_nxt;
                r_y   <= w_y_nxt;
                r_z   <= w_z_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign io_out_cos = r_cos;
    assign io_out_sin = r_sin;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Bench for cordic_sincos_iter: directed corner angles plus random angles checked against real-valued sin/cos.
module tb_cordic_sincos_iter;

    localparam int ITERS   = 22;
    localparam int TOL     = 16;
    localparam int HALF_PI = 6588397;
    localparam int ONE     = 4194304;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [23:0] io_in_theta;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [23:0] io_out_cos;
    logic [23:0] io_out_sin;
    logic        io_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cordic_sincos_iter #(.WIDTH(24), .FRAC(22), .ITERS(ITERS)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_theta  (io_in_theta),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_cos   (io_out_cos),
        .io_out_sin   (io_out_sin),
        .io_busy      (io_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int clamp(input int th);
        if (th > HALF_PI) return HALF_PI;
        if (th < -HALF_PI) return -HALF_PI;
        return th;
    endfunction

    function automatic int model_cos(input int th);
        real a;
        a = real'(clamp(th)) / real'(ONE);
        return int'($cos(a) * real'(ONE));
    endfunction

    function automatic int model_sin(input int th);
        real a;
        a = real'(clamp(th)) / real'(ONE);
        return int'($sin(a) * real'(ONE));
    endfunction

    function automatic int sx(input logic [23:0] v);
        return int'($signed(v));
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rand_theta();
        return int'($urandom_range(2 * HALF_PI)) - HALF_PI;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents th and returns just after the accepting edge; ok=0 if the engine never became ready.
    task automatic start(input int th, output bit ok);
        int n;
        io_in_theta = th[23:0];
        io_in_valid = 1'b1;
        n = 0;
        while (!io_in_ready && n < 60) begin
            tick();
            n++;
        end
        ok = io_in_ready;
        tick();
        io_in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!io_out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_out();
        io_out_ready = 1'b1;
        tick();
        io_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        io_in_valid = 1'b0;
        io_out_ready = 1'b0;
        io_in_theta = '0;
        tick();
        tick();
        total++;
        if ({io_in_ready, io_out_valid, io_busy} !== 3'b100) begin
            bad++;
            $display("FAIL reset_flags got ready/valid/busy=%b want=100", {io_in_ready, io_out_valid, io_busy});
        end
        total++;
        if (io_out_cos !== 24'd0 || io_out_sin !== 24'd0) begin
            bad++;
            $display("FAIL reset_data got cos=%0d sin=%0d want 0 0", sx(io_out_cos), sx(io_out_sin));
        end
        reset = 1'b0;
        tick();
        total++;
        if (io_in_ready !== 1'b1 || io_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got ready=%b busy=%b want 1 0", io_in_ready, io_busy);
        end
    endtask

    task automatic test_zero();
        bit ok;
        int lat;
        start(0, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL zero_accept got in_ready=0 want 1");
        end
        total++;
        if (io_in_ready !== 1'b0 || io_busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_run_flags got ready=%b busy=%b want 0 1", io_in_ready, io_busy);
        end
        wait_out(lat);
        total++;
        if (lat != ITERS + 1) begin
            bad++;
            $display("FAIL zero_latency got %0d want %0d", lat, ITERS + 1);
        end
        total++;
        if (iabs(sx(io_out_cos) - ONE) > TOL || iabs(sx(io_out_sin)) > TOL) begin
            bad++;
            $display("FAIL zero_value got cos=%0d sin=%0d want %0d 0 (+/-%0d)", sx(io_out_cos), sx(io_out_sin), ONE, TOL);
        end
        finish_out();
        total++;
        if ({io_in_ready, io_out_valid, io_busy} !== 3'b100) begin
            bad++;
            $display("FAIL zero_release got ready/valid/busy=%b want 100", {io_in_ready, io_out_valid, io_busy});
        end
    endtask

    task automatic test_corners();
        int th   [4] = '{3294198, -8000000, 8000000, -3294198};
        int ec   [4] = '{2965821, 0, 0, 2965821};
        int es   [4] = '{2965821, -ONE, ONE, -2965821};
        bit ok;
        int lat;
        for (int k = 0; k < 4; k++) begin
            start(th[k], ok);
            wait_out(lat);
            total++;
            if (!ok || lat != ITERS + 1) begin
                bad++;
                $display("FAIL corner%0d_handshake got ok=%0d lat=%0d want 1 %0d", k, ok, lat, ITERS + 1);
            end
            total++;
            if (iabs(sx(io_out_cos) - ec[k]) > TOL || iabs(sx(io_out_sin) - es[k]) > TOL) begin
                bad++;
                $display("FAIL corner%0d_value theta=%0d got cos=%0d sin=%0d want %0d %0d",
                         k, th[k], sx(io_out_cos), sx(io_out_sin), ec[k], es[k]);
            end
            finish_out();
        end
    endtask

    task automatic test_stall();
        bit ok;
        int lat;
        int th;
        logic [23:0] c0, s0;
        th = rand_theta();
        start(th, ok);
        wait_out(lat);
        c0 = io_out_cos;
        s0 = io_out_sin;
        total++;
        if (iabs(sx(c0) - model_cos(th)) > TOL || iabs(sx(s0) - model_sin(th)) > TOL) begin
            bad++;
            $display("FAIL stall_value theta=%0d got cos=%0d sin=%0d want %0d %0d",
                     th, sx(c0), sx(s0), model_cos(th), model_sin(th));
        end
        io_in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if ({io_out_valid, io_in_ready, io_busy, io_out_cos, io_out_sin} !== {3'b101, c0, s0}) begin
                bad++;
                $display("FAIL stall_hold cycle=%0d got valid/ready/busy=%b cos=%0d sin=%0d want 101 %0d %0d",
                         k, {io_out_valid, io_in_ready, io_busy}, sx(io_out_cos), sx(io_out_sin), sx(c0), sx(s0));
            end
        end
        io_in_valid = 1'b0;
        finish_out();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        start(rand_theta(), ok);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({io_in_ready, io_out_valid, io_busy} !== 3'b100 || io_out_cos !== 24'd0 || io_out_sin !== 24'd0) begin
            bad++;
            $display("FAIL reset_in_run got ready/valid/busy=%b cos=%0d sin=%0d want 100 0 0",
                     {io_in_ready, io_out_valid, io_busy}, sx(io_out_cos), sx(io_out_sin));
        end
        start(0, ok);
        wait_out(lat);
        total++;
        if (lat != ITERS + 1 || iabs(sx(io_out_cos) - ONE) > TOL || iabs(sx(io_out_sin)) > TOL) begin
            bad++;
            $display("FAIL after_reset_run got lat=%0d cos=%0d sin=%0d want %0d %0d 0",
                     lat, sx(io_out_cos), sx(io_out_sin), ITERS + 1, ONE);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({io_in_ready, io_out_valid, io_busy} !== 3'b100 || io_out_cos !== 24'd0 || io_out_sin !== 24'd0) begin
            bad++;
            $display("FAIL reset_in_done got ready/valid/busy=%b cos=%0d sin=%0d want 100 0 0",
                     {io_in_ready, io_out_valid, io_busy}, sx(io_out_cos), sx(io_out_sin));
        end
    endtask

    // Period = accept-to-valid latency, one edge for the output handshake, one IDLE edge for the next accept.
    task automatic test_back_to_back();
        int th, lat, n, acc, prev_acc;
        prev_acc = 0;
        io_out_ready = 1'b1;
        io_in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            th = rand_theta();
            io_in_theta = th[23:0];
            n = 0;
            while (!io_in_ready && n < 60) begin
                tick();
                n++;
            end
            tick();
            acc = cyc;
            if (k > 0) begin
                total++;
                if (acc - prev_acc != ITERS + 3) begin
                    bad++;
                    $display("FAIL b2b_period k=%0d got %0d want %0d", k, acc - prev_acc, ITERS + 3);
                end
            end
            prev_acc = acc;
            wait_out(lat);
            total++;
            if (lat != ITERS + 1 || iabs(sx(io_out_cos) - model_cos(th)) > TOL
                || iabs(sx(io_out_sin) - model_sin(th)) > TOL) begin
                bad++;
                $display("FAIL b2b_value k=%0d theta=%0d got lat=%0d cos=%0d sin=%0d want %0d %0d %0d",
                         k, th, lat, sx(io_out_cos), sx(io_out_sin), ITERS + 1, model_cos(th), model_sin(th));
            end
        end
        io_in_valid = 1'b0;
        tick();
        io_out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_corners();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
